fetch_bp: RTL and testbench
===========================

Name: fetch_bp

Overview:
- Parametrised fetch stage with a dynamic branch predictor and a memory handshake.
- Issues one instruction-memory request at a time and tolerates variable memory latency.
- Predicts branches with a 2-bit saturating Branch History Table (BHT); JAL is always taken.
- Redirects on mispredict from execute and presents a registered instruction/PC/prediction bundle to decode.

Parameters:
- XLEN, 64, address/PC width.
- ILEN, 64, instruction word width; opcode is instr[7:0], sign bit is instr[ILEN-1].
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of two ≥ 2.
- PC_INC, 4, sequential PC increment in bytes.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  decode cannot accept; hold the output bundle
- flush_in  in  1  replace the next captured instruction with a NOP
- redirect_in  in  1  branch mispredicted; restart fetch at redirect_pc_in
- redirect_pc_in  in  XLEN  corrected PC
- bht_update_in  in  1  resolved conditional branch this cycle
- bht_update_pc_in  in  XLEN  PC of the resolved branch
- bht_update_taken_in  in  1  resolved direction
- imem_req_valid_out  out  1  request valid
- imem_req_ready_in  in  1  memory accepts the request
- imem_addr_out  out  XLEN  request address
- imem_resp_valid_in  in  1  response data valid
- imem_resp_data_in  in  ILEN  fetched instruction
- instr_valid_out  out  1  bundle valid
- instr_out  out  ILEN  instruction
- pc_out  out  XLEN  instruction PC
- branch_predicted_taken_out  out  1  prediction used for this instruction

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FSM=ISSUE.
  - All outputs 0, except instr_out=INSTR_NOP.
  - All BHT counters=2'b01 (weakly not-taken).
- FSM:
  - ISSUE: drive imem_req_valid_out=1, imem_addr_out=fetch_pc. Go to WAIT when imem_req_ready_in=1.
  - WAIT: on imem_resp_valid_in, capture the response. Go to ISSUE if the output slot is free or being drained (stall_in=0); otherwise go to HOLD with the data in a one-entry skid register.
  - WAIT_KILL: entered from WAIT on redirect. Discard the pending response, then go to ISSUE.
  - HOLD: wait for stall_in=0, move the skid entry to the output, then go to ISSUE.
- Only one outstanding request. Address and valid stay stable while valid=1 and ready=0.
- Prediction, computed on response data:
  - imm_j = sext({i[40:24], i[40], i[60:50], i[48:42], 1'b0}).
  - imm_b = sext({i[7], i[60:50], i[24:16], 1'b0}).
  - Sign-extension uses i[ILEN-1].
  - JAL: taken, next = pc + imm_j.
  - BRANCH: taken iff bht[idx][1], next = pc + imm_b when taken.
  - Otherwise: next = pc + PC_INC.
  - idx = pc[$clog2(BHT_ENTRIES)+1:2].
  - All arithmetic is modulo 2^XLEN.
- BHT update: saturating increment if taken, decrement if not; never wraps past 2'b11 or 2'b00. When a lookup and an update hit the same index in the same cycle, the lookup sees the pre-update value.
- Redirect has highest priority:
  - fetch_pc ← redirect_pc_in next cycle.
  - In ISSUE with a request not yet accepted: the address may change.
  - In WAIT: go to WAIT_KILL, or directly to ISSUE if the response arrives in the same cycle (that response is dropped).
  - In HOLD: drop the skid entry.
  - Output bundle: instr_valid_out ← 0 next cycle.
- Output register:
  - Updates only when stall_in=0.
  - Loads a new instruction: valid=1, pc, prediction.
  - If nothing is captured: instr_valid_out ← 0.
- flush_in with stall_in=0: instr_out ← INSTR_NOP, instr_valid_out ← 0, branch_predicted_taken_out ← 0.
- Latency:
  - Zero-wait memory: request accepted at cycle n, response at n+1, bundle visible at n+2.
  - Back-to-back throughput: one instruction per 2 cycles.
- Reset mid-WAIT: the pending response is ignored; the first new request goes to RESET_PC.

Decomposition:
- Shared opcodes package: JAL, BRANCH, INSTR_NOP, and the fetch FSM state enum.
- Add imm_j/imm_b extraction functions to the package for reuse by decode.
- Sub-module fetch_bht: counter array with lookup port and update port, parametrised by BHT_ENTRIES, reset via rst_n.

Test Plan:
- Reset release, memory always ready, 4 non-branch words → addresses 0x0, 0x4, 0x8, 0xC; pc_out matches; predicted_taken=0.
- JAL at 0x10 with imm_j=+0x40 → next request address 0x50; branch_predicted_taken_out=1 with pc_out=0x10.
- BRANCH at 0x20, offset +0x8:
  - First fetch not taken (counter 01) → 0x24.
  - Two bht_update_taken_in=1 updates, refetch → taken, next 0x28.
  - Three not-taken updates → counter saturates at 00.
- Memory ready held low 3 cycles, then redirect_in to 0x100 while in WAIT → stale response dropped; next request 0x100; no bundle emitted with the stale PC.
- stall_in high 5 cycles while a response arrives → FSM in HOLD; outputs stable; on release the held instruction appears once, then fetch resumes.
- flush_in with stall_in=0 as data arrives → instr_out=INSTR_NOP, instr_valid_out=0; assert rst_n low mid-WAIT → all outputs cleared asynchronously, first request after release is 0x0.

Source files
------------

// File: rtl/fetch_bp_pkg.sv
// Shared definitions for the fetch stage: opcodes, NOP encoding, the fetch
// FSM state type and immediate/counter helpers reused by decode.
package fetch_bp_pkg;

  localparam logic [7:0]  OPC_JAL    = 8'h6F;
  localparam logic [7:0]  OPC_BRANCH = 8'h63;
  localparam logic [63:0] INSTR_NOP  = 64'h0000_0000_0000_0013;

  typedef enum logic [1:0] {
    ST_ISSUE     = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_KILL = 2'd2,
    ST_HOLD      = 2'd3
  } fetch_state_e;

  // JAL offset; s is the instruction sign bit used for extension.
  function automatic logic [63:0] imm_j(input logic [63:0] i, input logic s);
    return {{27{s}}, i[40:24], i[40], i[60:50], i[48:42], 1'b0};
  endfunction

  // Conditional branch offset; s is the instruction sign bit.
  function automatic logic [63:0] imm_b(input logic [63:0] i, input logic s);
    return {{42{s}}, i[7], i[60:50], i[24:16], 1'b0};
  endfunction

  // Two-bit saturating counter step.
  function automatic logic [1:0] sat_ctr_step(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken && c != 2'b11) r = c + 2'b01;
    else if (!taken && c != 2'b00) r = c - 2'b01;
    return r;
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational lookup port and one registered update port.
module fetch_bht
  import fetch_bp_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc_in,
  output logic            lookup_taken_out,
  input  logic            upd_valid_in,
  input  logic [XLEN-1:0] upd_pc_in,
  input  logic            upd_taken_in
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       cnt_q [BHT_ENTRIES];
  logic [1:0]       cnt_d [BHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_pc_bits;

  assign lookup_idx = lookup_pc_in[IDX_W+1:2];
  assign upd_idx    = upd_pc_in[IDX_W+1:2];
  assign unused_pc_bits = ^{lookup_pc_in[XLEN-1:IDX_W+2], lookup_pc_in[1:0],
                            upd_pc_in[XLEN-1:IDX_W+2], upd_pc_in[1:0]};

  // Lookup reads the registered counter, so a same-cycle update is not visible.
  assign lookup_taken_out = cnt_q[lookup_idx][1];

  // Next counter values: only the indexed entry moves on an update.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid_in) cnt_d[upd_idx] = sat_ctr_step(cnt_q[upd_idx], upd_taken_in);
  end

  // Counter storage; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BHT_ENTRIES; k++) cnt_q[k] <= 2'b01;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_bp.sv
// Fetch stage: one outstanding instruction-memory request, BHT/JAL based
// next-PC prediction, one-entry skid for decode back-pressure, and a
// registered instruction/PC/prediction bundle towards decode.
module fetch_bp
  import fetch_bp_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter int              ILEN        = 64,
  parameter int              BHT_ENTRIES = 64,
  parameter int unsigned     PC_INC      = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  input  logic            bht_update_in,
  input  logic [XLEN-1:0] bht_update_pc_in,
  input  logic            bht_update_taken_in,
  output logic            imem_req_valid_out,
  input  logic            imem_req_ready_in,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_resp_valid_in,
  input  logic [ILEN-1:0] imem_resp_data_in,
  output logic            instr_valid_out,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            branch_predicted_taken_out
);

  localparam logic [ILEN-1:0] NOP_W = ILEN'(INSTR_NOP);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [ILEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            skid_pred_q, skid_pred_d;
  logic            out_valid_q, out_valid_d;
  logic [ILEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            out_pred_q, out_pred_d;

  logic            bht_taken;
  logic [63:0]     resp_w;
  logic [7:0]      opc;
  logic            is_jal, is_br, pred_taken;
  logic [XLEN-1:0] imm_j_x, imm_b_x, next_pc;
  logic            load_new, load_skid;

  fetch_bht #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_pc_in     (fetch_pc_q),
    .lookup_taken_out (bht_taken),
    .upd_valid_in     (bht_update_in),
    .upd_pc_in        (bht_update_pc_in),
    .upd_taken_in     (bht_update_taken_in)
  );

  assign resp_w = 64'(imem_resp_data_in);

  // Predict the successor of the instruction arriving from memory.
  always_comb begin
    opc        = imem_resp_data_in[7:0];
    is_jal     = (opc == OPC_JAL);
    is_br      = (opc == OPC_BRANCH);
    imm_j_x    = XLEN'($signed(imm_j(resp_w, imem_resp_data_in[ILEN-1])));
    imm_b_x    = XLEN'($signed(imm_b(resp_w, imem_resp_data_in[ILEN-1])));
    pred_taken = is_jal | (is_br & bht_taken);
    next_pc    = fetch_pc_q + XLEN'(PC_INC);
    if (is_jal) next_pc = fetch_pc_q + imm_j_x;
    else if (is_br && bht_taken) next_pc = fetch_pc_q + imm_b_x;
  end

  // FSM next state, skid capture and output-bundle next values.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pred_d  = skid_pred_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pred_d   = out_pred_q;
    load_new     = 1'b0;
    load_skid    = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        // A request accepted alongside a redirect targets the old PC, so
        // its response must be discarded.
        if (imem_req_ready_in) state_d = redirect_in ? ST_WAIT_KILL : ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_resp_valid_in) begin
          state_d = ST_ISSUE;
          if (!redirect_in) begin
            fetch_pc_d = next_pc;
            if (stall_in) begin
              state_d      = ST_HOLD;
              skid_instr_d = imem_resp_data_in;
              skid_pc_d    = fetch_pc_q;
              skid_pred_d  = pred_taken;
            end else begin
              load_new = 1'b1;
            end
          end
        end else if (redirect_in) begin
          state_d = ST_WAIT_KILL;
        end
      end
      ST_WAIT_KILL: begin
        if (imem_resp_valid_in) state_d = ST_ISSUE;
      end
      ST_HOLD: begin
        if (redirect_in) begin
          state_d = ST_ISSUE;
        end else if (!stall_in) begin
          state_d   = ST_ISSUE;
          load_skid = 1'b1;
        end
      end
      default: state_d = ST_ISSUE;
    endcase

    if (!stall_in) begin
      if (flush_in) begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_W;
        out_pred_d  = 1'b0;
      end else if (load_new) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_resp_data_in;
        out_pc_d    = fetch_pc_q;
        out_pred_d  = pred_taken;
      end else if (load_skid) begin
        out_valid_d = 1'b1;
        out_instr_d = skid_instr_q;
        out_pc_d    = skid_pc_q;
        out_pred_d  = skid_pred_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (redirect_in) begin
      fetch_pc_d  = redirect_pc_in;
      out_valid_d = 1'b0;
    end
  end

  // State, fetch PC, skid entry and output bundle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ISSUE;
      fetch_pc_q   <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pred_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_W;
      out_pc_q     <= '0;
      out_pred_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pred_q  <= skid_pred_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pred_q   <= out_pred_d;
    end
  end

  // Request outputs are forced low while reset is asserted.
  assign imem_req_valid_out         = rst_n & (state_q == ST_ISSUE);
  assign imem_addr_out              = rst_n ? fetch_pc_q : '0;
  assign instr_valid_out            = out_valid_q;
  assign instr_out                  = out_instr_q;
  assign pc_out                     = out_pc_q;
  assign branch_predicted_taken_out = out_pred_q;

endmodule

// File: tb/tb_fetch_bp.sv
module tb_fetch_bp;
  import fetch_bp_pkg::*;

  localparam int XLEN = 64;
  localparam int ILEN = 64;

  localparam logic [63:0] JAL_W = 64'h0000_8000_0000_006F; // imm_j = +0x40
  localparam logic [63:0] BR_W  = 64'h0000_0000_0004_0063; // imm_b = +0x8
  localparam logic [63:0] ALU_W = 64'h0000_0055_0000_0013;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall_in = 1'b0, flush_in = 1'b0;
  logic            redirect_in = 1'b0;
  logic [XLEN-1:0] redirect_pc_in = '0;
  logic            bht_update_in = 1'b0, bht_update_taken_in = 1'b0;
  logic [XLEN-1:0] bht_update_pc_in = '0;
  logic            imem_req_valid_out;
  logic            imem_req_ready_in = 1'b0;
  logic [XLEN-1:0] imem_addr_out;
  logic            imem_resp_valid_in = 1'b0;
  logic [ILEN-1:0] imem_resp_data_in = '0;
  logic            instr_valid_out;
  logic [ILEN-1:0] instr_out;
  logic [XLEN-1:0] pc_out;
  logic            branch_predicted_taken_out;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errs = 0;
  logic stall_s = 1'b0;

  fetch_bp #(
    .XLEN(XLEN), .ILEN(ILEN), .BHT_ENTRIES(64), .PC_INC(4), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .bht_update_in(bht_update_in), .bht_update_pc_in(bht_update_pc_in),
    .bht_update_taken_in(bht_update_taken_in),
    .imem_req_valid_out(imem_req_valid_out), .imem_req_ready_in(imem_req_ready_in),
    .imem_addr_out(imem_addr_out), .imem_resp_valid_in(imem_resp_valid_in),
    .imem_resp_data_in(imem_resp_data_in), .instr_valid_out(instr_valid_out),
    .instr_out(instr_out), .pc_out(pc_out),
    .branch_predicted_taken_out(branch_predicted_taken_out)
  );

  always #5 clk = ~clk;

  // Stall as seen by the DUT at the edge that may have loaded the bundle.
  always @(posedge clk) stall_s <= stall_in;

  // Scoreboard consumer: each newly loaded bundle must match the queue head.
  always @(negedge clk) begin
    if (rst_n && instr_valid_out && !stall_s) begin
      checks++;
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL bundle_unexpected: got pc=%h instr=%h, required no bundle", pc_out, instr_out);
      end else begin
        mon_e = sb_q.pop_front();
        if (pc_out !== mon_e.pc || instr_out !== mon_e.instr ||
            branch_predicted_taken_out !== mon_e.pred) begin
          errs++;
          $display("FAIL bundle: got pc=%h instr=%h pred=%b, required pc=%h instr=%h pred=%b",
                   pc_out, instr_out, branch_predicted_taken_out, mon_e.pc, mon_e.instr, mon_e.pred);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog expired");
  end

  // Wait for a request, check its address, accept it and answer next cycle.
  task automatic issue_and_respond(input logic [XLEN-1:0] exp_addr, input logic [ILEN-1:0] data,
                                   input logic exp_pred, input bit push);
    int t = 0;
    while (imem_req_valid_out !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (imem_req_valid_out !== 1'b1) begin
      errs++;
      $display("FAIL req_timeout: req_valid=%b, required 1 (expected addr %h)", imem_req_valid_out, exp_addr);
    end
    checks++;
    if (imem_addr_out !== exp_addr) begin
      errs++;
      $display("FAIL req_addr: got %h, required %h", imem_addr_out, exp_addr);
    end
    imem_req_ready_in = 1'b1;
    @(negedge clk);
    imem_req_ready_in  = 1'b0;
    imem_resp_valid_in = 1'b1;
    imem_resp_data_in  = data;
    if (push) sb_q.push_back('{pc: exp_addr, instr: data, pred: exp_pred});
    @(negedge clk);
    imem_resp_valid_in = 1'b0;
  endtask

  task automatic redirect_to(input logic [XLEN-1:0] pc);
    redirect_in    = 1'b1;
    redirect_pc_in = pc;
    @(negedge clk);
    redirect_in = 1'b0;
  endtask

  task automatic bht_train(input logic taken, input int n);
    bht_update_in       = 1'b1;
    bht_update_pc_in    = 64'h20;
    bht_update_taken_in = taken;
    repeat (n) @(negedge clk);
    bht_update_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (imem_req_valid_out !== 1'b0) begin errs++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid_out); end
    checks++; if (imem_addr_out !== 64'h0) begin errs++; $display("FAIL rst_addr: got %h, required 0", imem_addr_out); end
    checks++; if (instr_valid_out !== 1'b0) begin errs++; $display("FAIL rst_instr_valid: got %b, required 0", instr_valid_out); end
    checks++; if (instr_out !== INSTR_NOP) begin errs++; $display("FAIL rst_instr: got %h, required %h", instr_out, INSTR_NOP); end
    checks++; if (pc_out !== 64'h0) begin errs++; $display("FAIL rst_pc: got %h, required 0", pc_out); end
    checks++; if (branch_predicted_taken_out !== 1'b0) begin errs++; $display("FAIL rst_pred: got %b, required 0", branch_predicted_taken_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      issue_and_respond(64'(i * 4), 64'h13 + (64'(i + 1) << 32), 1'b0, 1'b1);
      if (i == 0) begin
        checks++;
        if (instr_valid_out !== 1'b1) begin errs++; $display("FAIL latency: instr_valid=%b two cycles after accept, required 1", instr_valid_out); end
      end
    end
  endtask

  task automatic test_jal();
    issue_and_respond(64'h10, JAL_W, 1'b1, 1'b1);
    issue_and_respond(64'h50, ALU_W, 1'b0, 1'b1);
  endtask

  task automatic test_branch();
    logic [XLEN-1:0] exp_next [4] = '{64'h24, 64'h28, 64'h24, 64'h24};
    logic            exp_pred [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    redirect_to(64'h20);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) bht_train(1'b1, 2);            // 01 -> 11
      if (k == 2) bht_train(1'b0, 3);            // 11 -> 00
      if (k == 3) begin bht_train(1'b0, 1); bht_train(1'b1, 1); end // 00 stays, -> 01
      if (k == 4) bht_train(1'b1, 1);            // 01 -> 10
      if (k > 0) redirect_to(64'h20);
      issue_and_respond(64'h20, BR_W, (k < 4) ? exp_pred[k] : 1'b1, 1'b1);
      checks++;
      if (imem_addr_out !== ((k < 4) ? exp_next[k] : 64'h28)) begin
        errs++;
        $display("FAIL br_next_%0d: got %h, required %h", k, imem_addr_out, (k < 4) ? exp_next[k] : 64'h28);
      end
    end
  endtask

  task automatic test_redirect_wait();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid_out !== 1'b1 || imem_addr_out !== 64'h28) begin
        errs++; $display("FAIL req_stable_%0d: got valid=%b addr=%h, required 1/%h", c, imem_req_valid_out, imem_addr_out, 64'h28);
      end
    end
    imem_req_ready_in = 1'b1;
    @(negedge clk);
    imem_req_ready_in = 1'b0;
    redirect_to(64'h100);
    checks++;
    if (imem_req_valid_out !== 1'b0 || instr_valid_out !== 1'b0) begin
      errs++; $display("FAIL kill_wait: got req_valid=%b instr_valid=%b, required 0/0", imem_req_valid_out, instr_valid_out);
    end
    imem_resp_valid_in = 1'b1;
    imem_resp_data_in  = JAL_W;
    @(negedge clk);
    imem_resp_valid_in = 1'b0;
    issue_and_respond(64'h100, ALU_W + 64'h100, 1'b0, 1'b1);
    // Redirect coinciding with the response drops it and returns to issue.
    imem_req_ready_in = 1'b1;
    @(negedge clk);
    imem_req_ready_in  = 1'b0;
    imem_resp_valid_in = 1'b1;
    imem_resp_data_in  = JAL_W;
    redirect_in        = 1'b1;
    redirect_pc_in     = 64'h200;
    @(negedge clk);
    imem_resp_valid_in = 1'b0;
    redirect_in        = 1'b0;
    checks++;
    if (imem_req_valid_out !== 1'b1 || imem_addr_out !== 64'h200) begin
      errs++; $display("FAIL redirect_same_cycle: got valid=%b addr=%h, required 1/%h", imem_req_valid_out, imem_addr_out, 64'h200);
    end
    issue_and_respond(64'h200, ALU_W + 64'h200, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    logic            v0;
    logic [ILEN-1:0] i0;
    logic [XLEN-1:0] p0;
    stall_in = 1'b1;
    v0 = instr_valid_out; i0 = instr_out; p0 = pc_out;
    issue_and_respond(64'h204, ALU_W + 64'h204, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (instr_valid_out !== v0 || instr_out !== i0 || pc_out !== p0 || imem_req_valid_out !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h req=%b, required v=%b pc=%h req=0",
                 c, instr_valid_out, pc_out, imem_req_valid_out, v0, p0);
      end
      @(negedge clk);
    end
    stall_in = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid_out !== 1'b1 || imem_addr_out !== 64'h208) begin
      errs++; $display("FAIL stall_resume: got valid=%b addr=%h, required 1/%h", imem_req_valid_out, imem_addr_out, 64'h208);
    end
    @(negedge clk);
    checks++;
    if (instr_valid_out !== 1'b0) begin errs++; $display("FAIL stall_once: instr_valid=%b, required 0", instr_valid_out); end
  endtask

  task automatic test_flush();
    flush_in = 1'b1;
    issue_and_respond(64'h208, ALU_W + 64'h208, 1'b0, 1'b0);
    flush_in = 1'b0;
    checks++; if (instr_out !== INSTR_NOP) begin errs++; $display("FAIL flush_instr: got %h, required %h", instr_out, INSTR_NOP); end
    checks++; if (instr_valid_out !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b, required 0", instr_valid_out); end
    checks++; if (branch_predicted_taken_out !== 1'b0) begin errs++; $display("FAIL flush_pred: got %b, required 0", branch_predicted_taken_out); end
    checks++; if (imem_addr_out !== 64'h20C) begin errs++; $display("FAIL flush_next: got %h, required %h", imem_addr_out, 64'h20C); end
  endtask

  task automatic test_reset_mid_wait();
    issue_and_respond(64'h20C, ALU_W + 64'h20C, 1'b0, 1'b1);
    stall_in = 1'b1;
    imem_req_ready_in = 1'b1;
    @(negedge clk);
    imem_req_ready_in = 1'b0;
    checks++;
    if (instr_valid_out !== 1'b1 || imem_req_valid_out !== 1'b0) begin
      errs++; $display("FAIL pre_reset: got instr_valid=%b req_valid=%b, required 1/0", instr_valid_out, imem_req_valid_out);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid_out !== 1'b0) begin errs++; $display("FAIL async_valid: got %b, required 0", instr_valid_out); end
    checks++; if (instr_out !== INSTR_NOP) begin errs++; $display("FAIL async_instr: got %h, required %h", instr_out, INSTR_NOP); end
    checks++; if (pc_out !== 64'h0) begin errs++; $display("FAIL async_pc: got %h, required 0", pc_out); end
    checks++; if (imem_req_valid_out !== 1'b0) begin errs++; $display("FAIL async_req: got %b, required 0", imem_req_valid_out); end
    stall_in = 1'b0;
    @(negedge clk);
    imem_resp_valid_in = 1'b1;
    imem_resp_data_in  = JAL_W;
    @(negedge clk);
    imem_resp_valid_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    issue_and_respond(64'h0, ALU_W, 1'b0, 1'b1);
    checks++; if (imem_addr_out !== 64'h4) begin errs++; $display("FAIL post_reset_next: got %h, required %h", imem_addr_out, 64'h4); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_redirect_wait();
    test_stall();
    test_flush();
    test_reset_mid_wait();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errs++; $display("FAIL scoreboard_drain: %0d bundles outstanding, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
